param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 177 +++++++++++++++++
 tb/tb_param_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with registered read data, registered status
// flags and one-cycle overflow/underflow pulses. Depth is 2**ADDR_W words.
//
// Optional feature: define PARAM_FIFO_STALL_EN to add a 16-bit LFSR driven
// read-stall generator. After each accepted read, rd_ready stays low for
// 0..7 cycles. Without the macro, rd_ready simply follows !empty.
//
// Memory contents are deliberately left unreset. count and the pointers are
// cleared, so stale words can never be read out.

module param_fifo #(
    parameter int          DATA_W    = 8,
    parameter int          ADDR_W    = 8,
    parameter int          AF_LEVEL  = (1 << ADDR_W) - 4,
    parameter int          AE_LEVEL  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              rd_ready,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              rd_ready_q, rd_ready_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              almost_empty_q, almost_empty_d;
    logic              almost_full_q, almost_full_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              rd_accept_s;
    logic              wr_accept_s;
    logic [2:0]        stall_next_s;

`ifdef PARAM_FIFO_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  stall_q;

    // Free-running Fibonacci LFSR and the post-read stall countdown.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (rd_accept_s) begin
            stall_next_s = lfsr_q[2:0];
        end else if (stall_q != 3'd0) begin
            stall_next_s = stall_q - 3'd1;
        end else begin
            stall_next_s = stall_q;
        end
    end

    // LFSR and stall counter state; the LFSR restarts from the seed on reset.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            lfsr_q  <= LFSR_SEED;
            stall_q <= 3'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            stall_q <= stall_next_s;
        end
    end
`else
    assign stall_next_s = 3'd0;
`endif

    // Handshake decisions, pointer/count update and next-cycle flag values.
    always_comb begin
        // rd_ready_q already folds in both "not empty" and "stall expired".
        rd_accept_s = rd_en && rd_ready_q;
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        wr_accept_s = wr_en && (!full_q || rd_accept_s);

        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_accept_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            dout_d   = mem[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            dout_d   = dout_q;
        end

        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Flags come from count_d so they change on the same edge as count.
        valid_d        = rd_accept_s;
        empty_d        = (count_d == (ADDR_W+1)'(0));
        full_d         = (count_d == DEPTH_C);
        almost_empty_d = (count_d <= AE_C);
        almost_full_d  = (count_d >= AF_C);
        rd_ready_d     = (count_d != (ADDR_W+1)'(0)) && (stall_next_s == 3'd0);
        overflow_d     = wr_en && !wr_accept_s;
        // A read held off only by the stall counter is not an error.
        underflow_d    = rd_en && empty_q;
    end

    // Storage array write port; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            dout_q         <= '0;
            valid_q        <= 1'b0;
            rd_ready_q     <= 1'b0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            dout_q         <= dout_d;
            valid_q        <= valid_d;
            rd_ready_q     <= rd_ready_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign dout         = dout_q;
    assign valid        = valid_q;
    assign rd_ready     = rd_ready_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = almost_empty_q;
    assign almost_full  = almost_full_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (default parameters, DEPTH = 256).
// A cycle-level reference model decides acceptance. Words read from the model
// storage go into a scoreboard queue, and are popped when the DUT asserts valid.

module tb_param_fifo;

    localparam int          DEPTH = 256;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       clk = 1'b0;
    logic       srst;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       valid, rd_ready, empty, full, almost_empty, almost_full;
    logic [8:0] count;
    logic       overflow, underflow;

    param_fifo dut (
        .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .valid(valid), .rd_ready(rd_ready), .empty(empty),
        .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_count;
    int          m_stall;
    logic [15:0] m_lfsr;
    logic [7:0]  exp_dout;
    logic [7:0]  mem_q [$];
    logic [7:0]  sb_q  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_stall  = 0;
        m_lfsr   = SEED;
        exp_dout = 8'h00;
        mem_q.delete();
        sb_q.delete();
    endtask

    // One clock: predict the edge from current inputs, advance, then check.
    task automatic cycle();
        logic rd_acc, wr_acc, e_ovf, e_udf;
        rd_acc = rd_en && (m_count != 0) && (m_stall == 0);
        wr_acc = wr_en && ((m_count != DEPTH) || rd_acc);
        e_ovf  = wr_en && !wr_acc;
        e_udf  = rd_en && (m_count == 0);
        if (rd_acc) sb_q.push_back(mem_q.pop_front());
        if (wr_acc) mem_q.push_back(din);
        if (wr_acc && !rd_acc) m_count++;
        if (rd_acc && !wr_acc) m_count--;
`ifdef PARAM_FIFO_STALL_EN
        if (rd_acc) m_stall = int'(m_lfsr[2:0]);
        else if (m_stall != 0) m_stall--;
`endif
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        @(posedge clk);
        #1;
        check("valid", valid, rd_acc);
        if (valid && sb_q.size() > 0) exp_dout = sb_q.pop_front();
        check("dout", dout, exp_dout);
        check("count", count, m_count);
        check("empty", empty, m_count == 0);
        check("full", full, m_count == DEPTH);
        check("almost_empty", almost_empty, m_count <= 4);
        check("almost_full", almost_full, m_count >= DEPTH - 4);
        check("overflow", overflow, e_ovf);
        check("underflow", underflow, e_udf);
        check("rd_ready", rd_ready, (m_count != 0) && (m_stall == 0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_ae"}, almost_empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_af"}, almost_full, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_rd_ready"}, rd_ready, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_udf"}, underflow, 0);
    endtask

    initial begin
        int n_valid;
        int n_cyc;
        srst  = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        srst = 1'b0;

        // Fill 0x00..0xFF, watching the almost_empty / almost_full crossings.
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            din = 8'(i);
            cycle();
            if (i == 3)   check("ae_at_4", almost_empty, 1);
            if (i == 4)   check("ae_at_5", almost_empty, 0);
            if (i == 250) check("af_at_251", almost_full, 0);
            if (i == 251) check("af_at_252", almost_full, 1);
        end

        // One write too many.
        din = 8'h11;
        cycle();
        check("ovf_full", full, 1);
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 256);
        wr_en = 1'b0;
        cycle();

        // Full FIFO, simultaneous write and read.
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'hAA;
        cycle();
        check("fullrw_dout", dout, 8'h00);
        check("fullrw_count", count, 256);
        check("fullrw_ovf", overflow, 0);
        wr_en = 1'b0;

        // Drain everything; 0xAA must be the last word out.
        n_cyc = 0;
        while (m_count != 0 && n_cyc < 4000) begin
            cycle();
            n_cyc++;
        end
        check("drain_done", m_count, 0);
        check("drain_last", dout, 8'hAA);
        check("drain_empty", empty, 1);
        rd_en = 1'b0;
        repeat (8) cycle();
        check("sb_leftover", sb_q.size(), 0);

        // Empty FIFO, simultaneous write and read: only the write is taken.
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'h5A;
        cycle();
        check("emptyrw_udf", underflow, 1);
        check("emptyrw_valid", valid, 0);
        wr_en = 1'b0;
        cycle();
        check("emptyrw_read", dout, 8'h5A);
        check("emptyrw_rvalid", valid, 1);
        rd_en = 1'b0;
        repeat (8) cycle();

        // Back-to-back reads with rd_en held high.
        wr_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din = 8'(8'h80 + i);
            cycle();
        end
        wr_en   = 1'b0;
        rd_en   = 1'b1;
        n_valid = 0;
        n_cyc   = 0;
        while (n_valid < 32 && n_cyc < 400) begin
            cycle();
            n_cyc++;
            if (valid) n_valid++;
        end
        check("b2b_valids", n_valid, 32);
`ifndef PARAM_FIFO_STALL_EN
        check("b2b_cycles", n_cyc, 32);
`endif
        rd_en = 1'b0;
        cycle();

        // Reset in the middle of traffic, right after a read is accepted.
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'h3C;
        repeat (3) cycle();
        #2;
        srst = 1'b1;
        #1;
        check("async_valid", valid, 0);
        check("async_count", count, 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        srst  = 1'b0;
        model_reset();
        check_reset_state("midrst");
        cycle();
        check("post_rst_count", count, 0);
        check("post_rst_valid", valid, 0);
        check("post_rst_dout", dout, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
